// File: rtl/imem_line_buffer.sv
// imem_line_buffer: single-line instruction fetch buffer with
// word-by-word refill from a slower backing memory.
module imem_line_buffer #(
  parameter int WIDTH      = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] imem_data,
  output logic             imem_ready,
  input  logic             inval,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int TW = WIDTH - 2 - IW;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] line [LINE_WORDS];
  logic [TW-1:0]    tag;
  logic [TW-1:0]    fill_tag;
  logic             valid;
  logic             inval_pending;
  logic [IW-1:0]    k;

  logic [TW-1:0]    addr_tag;
  logic [IW-1:0]    addr_idx;
  logic             hit;
  logic             last;
  logic             unused_addr;

  assign addr_tag    = imem_addr[WIDTH-1 -: TW];
  assign addr_idx    = imem_addr[2 +: IW];
  assign unused_addr = ^imem_addr[1:0];
  assign hit  = (state == IDLE) && valid && (tag == addr_tag);
  assign last = mem_rvalid && (k == IW'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!hit) state_n = FILL;
      FILL:    if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    imem_ready = hit;
    imem_data  = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    if (hit) imem_data = line[addr_idx];
    if (state == FILL) begin
      mem_req  = 1'b1;
      mem_addr = {fill_tag, k, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid         <= 1'b0;
      inval_pending <= 1'b0;
      k             <= '0;
      tag           <= '0;
      fill_tag      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      if (hit) hit_count <= hit_count + 32'd1;
      unique case (state)
        IDLE: begin
          // a miss also drops valid: the line is about to be overwritten
          if (inval || !hit) valid <= 1'b0;
          if (!hit) begin
            fill_tag   <= addr_tag;
            k          <= '0;
            miss_count <= miss_count + 32'd1;
          end
        end
        FILL: begin
          if (inval)      inval_pending <= 1'b1;
          if (mem_rvalid) k <= k + 1'b1;
        end
        DONE: begin
          valid         <= !inval_pending && !inval;
          tag           <= fill_tag;
          inval_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == FILL && mem_rvalid)
      line[k] <= mem_rdata;
  end

endmodule

// File: tb/tb_imem_line_buffer.sv
// tb_imem_line_buffer: directed scenarios against a behavioural
// backing memory with configurable wait states.
module tb_imem_line_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        inval;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;
  int wait_cfg = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  imem_line_buffer #(.WIDTH(32), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .imem_ready(imem_ready),
    .inval     (inval),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 ^ (a * 32'h0001_0001);
  endfunction

  // backing memory: answers after wait_cfg idle request cycles
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= wait_cfg) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rom(mem_addr);
        wcnt       = 0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        wcnt       = wcnt + 1;
      end
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      wcnt       = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inval = 1'b0;
    imem_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inval = 1'b0;
    imem_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (imem_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got %b want 0", imem_ready);
    end
    checks++;
    if (imem_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0", imem_data);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req: got %b want 0", mem_req);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_maddr: got %h want 0", mem_addr);
    end
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0",
               hit_count, miss_count);
    end
  endtask

  task automatic test_cold_start();
    logic [31:0] reqs [4];
    int n_req = 0;
    int first = -1;
    wait_cfg = 0;
    do_reset();
    imem_addr = 32'h0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_req) begin
        if (n_req < 4) reqs[n_req] = mem_addr;
        n_req++;
      end
      if (imem_ready && first < 0) begin
        first = c;
        checks++;
        if (imem_data !== rom(32'h0)) begin
          errors++;
          $display("FAIL cold_data: got %h want %h",
                   imem_data, rom(32'h0));
        end
        checks++;
        if (miss_count !== 32'd1) begin
          errors++;
          $display("FAIL cold_miss: got %0d want 1", miss_count);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (first != 6) begin
      errors++;
      $display("FAIL cold_latency: got %0d want 6", first);
    end
    checks++;
    if (n_req != 4) begin
      errors++;
      $display("FAIL cold_nreq: got %0d want 4", n_req);
    end
    for (int i = 0; i < 4 && i < n_req; i++) begin
      checks++;
      if (reqs[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL cold_maddr%0d: got %h want %h",
                 i, reqs[i], 32'(i * 4));
      end
    end
    #1;
    checks++;
    if (hit_count !== 32'd14) begin
      errors++;
      $display("FAIL cold_hits: got %0d want 14", hit_count);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] pc = 32'h0;
    logic [31:0] bases [2];
    int n_req = 0;
    int n_base = 0;
    wait_cfg = 0;
    do_reset();
    for (int c = 0; c < 60 && pc < 32'h20; c++) begin
      imem_addr = pc;
      #1;
      if (mem_req) begin
        n_req++;
        if (mem_addr[3:0] == 4'h0) begin
          if (n_base < 2) bases[n_base] = mem_addr;
          n_base++;
        end
      end
      if (imem_ready) begin
        checks++;
        if (imem_data !== rom(pc)) begin
          errors++;
          $display("FAIL seq_data@%h: got %h want %h",
                   pc, imem_data, rom(pc));
        end
        pc = pc + 32'd4;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (pc !== 32'h20) begin
      errors++;
      $display("FAIL seq_timeout: pc %h want 20", pc);
    end
    checks++;
    if (n_req != 8 || n_base != 2) begin
      errors++;
      $display("FAIL seq_fills: got %0d req %0d fills want 8 2",
               n_req, n_base);
    end
    checks++;
    if (n_base == 2 && (bases[0] !== 32'h0 || bases[1] !== 32'h10)) begin
      errors++;
      $display("FAIL seq_bases: got %h %h want 0 10",
               bases[0], bases[1]);
    end
    checks++;
    if (hit_count !== 32'd8 || miss_count !== 32'd2) begin
      errors++;
      $display("FAIL seq_cnt: got %0d/%0d want 8/2",
               hit_count, miss_count);
    end
  endtask

  task automatic test_wait_states();
    int cnt [4] = '{0, 0, 0, 0};
    int bad = 0;
    int first = -1;
    logic [31:0] prev = 32'h0;
    wait_cfg = 2;
    do_reset();
    imem_addr = 32'h40;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_req) begin
        if (mem_addr[31:4] != 28'h4 || mem_addr < prev) bad++;
        cnt[mem_addr[3:2]]++;
        prev = mem_addr;
      end
      if (imem_ready && first < 0) begin
        first = c;
        checks++;
        if (imem_data !== rom(32'h40)) begin
          errors++;
          $display("FAIL wait_data: got %h want %h",
                   imem_data, rom(32'h40));
        end
      end
      @(negedge clk);
    end
    wait_cfg = 0;
    checks++;
    if (first != 14) begin
      errors++;
      $display("FAIL wait_latency: got %0d want 14", first);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_order: got %0d bad addrs want 0", bad);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 3) begin
        errors++;
        $display("FAIL wait_hold%0d: got %0d cycles want 3", i, cnt[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] want [8] = '{32'h00, 32'h04, 32'h08, 32'h0C,
                              32'h80, 32'h84, 32'h88, 32'h8C};
    logic [31:0] reqs [8];
    int n_req = 0;
    int first = -1;
    wait_cfg = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      imem_addr = (c >= 2) ? 32'h80 : 32'h0;
      #1;
      if (mem_req) begin
        if (n_req < 8) reqs[n_req] = mem_addr;
        n_req++;
      end
      if (imem_ready && first < 0) begin
        first = c;
        checks++;
        if (imem_data !== rom(32'h80)) begin
          errors++;
          $display("FAIL br_data: got %h want %h",
                   imem_data, rom(32'h80));
        end
        checks++;
        if (miss_count !== 32'd2) begin
          errors++;
          $display("FAIL br_miss: got %0d want 2", miss_count);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (first != 12) begin
      errors++;
      $display("FAIL br_latency: got %0d want 12", first);
    end
    checks++;
    if (n_req != 8) begin
      errors++;
      $display("FAIL br_nreq: got %0d want 8", n_req);
    end
    for (int i = 0; i < 8 && i < n_req; i++) begin
      checks++;
      if (reqs[i] !== want[i]) begin
        errors++;
        $display("FAIL br_maddr%0d: got %h want %h", i, reqs[i], want[i]);
      end
    end
  endtask

  task automatic test_inval();
    int first = -1;
    wait_cfg = 0;
    do_reset();
    imem_addr = 32'h20;
    for (int c = 0; c < 20; c++) begin
      inval = (c == 2) || (c == 13);
      #1;
      if (c == 6) begin
        checks++;
        if (imem_ready !== 1'b0) begin
          errors++;
          $display("FAIL inv_fill_ready: got %b want 0", imem_ready);
        end
      end
      if (c == 12) begin
        checks++;
        if (miss_count !== 32'd2) begin
          errors++;
          $display("FAIL inv_refill_miss: got %0d want 2", miss_count);
        end
      end
      if (c == 13) begin
        checks++;
        if (imem_ready !== 1'b1) begin
          errors++;
          $display("FAIL inv_idle_same: got %b want 1", imem_ready);
        end
      end
      if (c == 14) begin
        checks++;
        if (imem_ready !== 1'b0) begin
          errors++;
          $display("FAIL inv_idle_next: got %b want 0", imem_ready);
        end
      end
      if (imem_ready && first < 0) begin
        first = c;
        checks++;
        if (imem_data !== rom(32'h20)) begin
          errors++;
          $display("FAIL inv_data: got %h want %h",
                   imem_data, rom(32'h20));
        end
      end
      @(negedge clk);
    end
    inval = 1'b0;
    #1;
    checks++;
    if (first != 12) begin
      errors++;
      $display("FAIL inv_latency: got %0d want 12", first);
    end
    checks++;
    if (miss_count !== 32'd3) begin
      errors++;
      $display("FAIL inv_miss_total: got %0d want 3", miss_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    int first = -1;
    int first_req = -1;
    logic [31:0] req0 = 32'hFFFF_FFFF;
    wait_cfg = 0;
    do_reset();
    imem_addr = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL mid_k2: got req %b addr %h want 1 8",
               mem_req, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL mid_req: got req %b addr %h want 0 0",
               mem_req, mem_addr);
    end
    checks++;
    if (imem_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready: got %b want 0", imem_ready);
    end
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("FAIL mid_cnt: got %0d/%0d want 0/0",
               hit_count, miss_count);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int c = 5; c < 20; c++) begin
      #1;
      if (mem_req && first_req < 0) begin
        first_req = c;
        req0 = mem_addr;
      end
      if (imem_ready && first < 0) begin
        first = c;
        checks++;
        if (imem_data !== rom(32'h0) || miss_count !== 32'd1) begin
          errors++;
          $display("FAIL mid_refill: got %h/%0d want %h/1",
                   imem_data, miss_count, rom(32'h0));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (first_req != 5 || req0 !== 32'h0) begin
      errors++;
      $display("FAIL mid_restart: got cyc %0d addr %h want 5 0",
               first_req, req0);
    end
    checks++;
    if (first != 10) begin
      errors++;
      $display("FAIL mid_latency: got %0d want 10", first);
    end
  endtask

  initial begin
    reset      = 1'b1;
    inval      = 1'b0;
    imem_addr  = '0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    test_reset();
    test_cold_start();
    test_sequential();
    test_wait_states();
    test_branch();
    test_inval();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_line_buffer.md
# imem_line_buffer

Single-line instruction fetch buffer between the mips32_pipeline fetch port (imem_addr / imem_data / imem_ready) and a slower word-wide backing instruction memory. On a hit it returns the instruction combinationally with imem_ready=1. On a miss it deasserts imem_ready, refills the whole aligned line word-by-word through a req/rvalid handshake, then serves the core. It also keeps hit/miss counters alongside the core's performance counters.

## Interface
- WIDTH, 32, data/address width
- LINE_WORDS, 4, words per line; power of two, 2..16
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  in  WIDTH  core fetch address (PC); bits [1:0] ignored
- imem_data  out  WIDTH  instruction word; 32'h0 (NOP) when imem_ready=0
- imem_ready  out  1  imem_data is valid for imem_addr this cycle (combinational)
- inval  in  1  invalidate the line (one-cycle pulse)
- mem_req  out  1  word read request to backing memory
- mem_addr  out  WIDTH  word-aligned request address
- mem_rdata  in  WIDTH  returned word, valid when mem_rvalid=1
- mem_rvalid  in  1  backing memory accepts the request and returns data this cycle
- hit_count  out  32  cycles with imem_ready=1
- miss_count  out  32  number of fills started

## Operation
- Storage: LINE_WORDS x WIDTH data regs, tag reg, valid bit, inval_pending bit.
- Tag = imem_addr[WIDTH-1 : 2+log2(LINE_WORDS)]. Word index = imem_addr[1+log2(LINE_WORDS) : 2].
- Hit = valid && tag match && state==IDLE. imem_ready = hit. imem_data = line[index] when hit, else 0.
- FSM states:
  - IDLE: on miss, latch fill tag from imem_addr, clear word counter k, increment miss_count, and go to FILL. Otherwise stay in IDLE.
  - FILL: mem_req=1 and mem_addr = {fill_tag, k, 2'b00}. When mem_rvalid=1, write line[k]=mem_rdata and k++. When mem_rvalid=1 with k==LINE_WORDS-1, go to DONE.
  - DONE: valid is set to !inval_pending and tag = fill_tag. Clear inval_pending and go to IDLE.
- valid is cleared on entering FILL, because the line is being overwritten.
- Memory handshake:
  - mem_req and mem_addr are held stable until mem_rvalid.
  - mem_rvalid is honoured only while mem_req=1.
  - Words are requested in ascending order from the line base; there is no critical-word-first.
  - Zero-wait memory (rvalid in the same cycle as req) is legal.
- Core address change during FILL: the fill always completes for the latched tag; there is no abort. After DONE the FSM re-evaluates in IDLE and may miss again.
- inval:
  - In IDLE or DONE: valid=0 next cycle.
  - In FILL: sets inval_pending, so the completed line is not marked valid and the next IDLE cycle misses.
  - inval has priority over DONE setting valid.
- hit_count increments every cycle imem_ready=1. Both counters wrap modulo 2^32.
- Reset takes priority over all other inputs, including mid-fill. Reset values: state=IDLE, valid=0, inval_pending=0, k=0, counters=0. Data regs are not reset. Outputs after reset: mem_req=0, mem_addr=0, imem_ready=0, imem_data=0.

## Timing
- Hit: 0 added latency; imem_ready/imem_data are combinational from imem_addr and state.
- Miss detected at cycle t (IDLE): FILL spans t+1 .. t+L+W.
  - L = LINE_WORDS.
  - W = total wait cycles, i.e. cycles with mem_req=1 and mem_rvalid=0.
  - DONE occurs at t+L+W+1. The first hit cycle is t+L+W+2.
  - With zero-wait memory and LINE_WORDS=4, the miss penalty is 6 cycles of imem_ready=0, counting t.
- mem_req is never high in IDLE or DONE.
- Exactly LINE_WORDS words are accepted per fill.

## Test plan
- Cold start, zero-wait memory, imem_addr=0x00: imem_ready=0 for cycles 0..5; mem_addr sequence is 0x00, 0x04, 0x08, 0x0C; then imem_ready=1 with the ROM[0] word; miss_count=1.
- Sequential PC 0x00..0x1C, one per ready cycle: exactly 2 fills (bases 0x00 and 0x10); hit_count=8; miss_count=2.
- Memory with 2 wait cycles per word, addr 0x40: mem_req held for 3 cycles per word with a stable mem_addr; first ready occurs 14 cycles after the miss is detected.
- Branch-like address change to 0x80 during the fill of 0x00: the 0x00 fill completes (4 words), then a new fill at 0x80 starts; miss_count=2.
- inval pulse during FILL of line 0x20: the line is not valid after DONE, an immediate refill of 0x20 follows, and miss_count increments.
- Reset asserted mid-FILL (k=2): mem_req=0 next cycle, imem_ready=0, counters=0; a fresh fill from base restarts after reset is released.
